// File: rtl/lego_pkg.sv
// -----------------------------------------------------------------------------
// lego_pkg
//   Shared constants and types for the LEGv8 fetch front end.
//   INSTR_W       : instruction word width.
//   PC_STEP       : byte distance between sequential instructions.
//   PC_W          : default PC width of the core.
//   fetch_entry_t : one fetched {pc, instr} pair at the default PC width.
// -----------------------------------------------------------------------------
package lego_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam int PC_W    = 64;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage : lego_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Small synchronous FIFO with flush and an occupancy counter. The head entry
//   is read combinationally from the read pointer. Storage is cleared by the
//   asynchronous reset so the head reads as zero straight out of reset.
//   Ports:
//     clk      : rising-edge clock
//     rst_n    : asynchronous active-low reset
//     flush_i  : drop every entry; overrides push and pop
//     push_i   : write wdata_i (accepted when not full, or when popping)
//     pop_i    : advance the head (ignored while empty)
//     wdata_i  : entry to write
//     rdata_o  : current head entry
//     count_o  : number of valid entries
//     full_o   : count_o == DEPTH
//     empty_o  : count_o == 0
//   DEPTH must be a power of two and at least 2 so pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop on an empty FIFO is dropped; a push into a full FIFO only lands
  // when the head leaves in the same cycle (it reuses the freed slot).
  assign do_pop_s  = pop_i & ~empty_o & ~flush_i;
  assign do_push_s = push_i & (~full_o | do_pop_s) & ~flush_i;

  // Next-state for pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule : sync_fifo

// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//   Instruction-fetch stage of the pipelined LEGv8 core. Owns the PC, drives
//   the instruction memory address, and queues fetched {pc, instr} pairs so
//   decode can stall without losing words. A taken branch flushes the queue
//   and reloads the PC with the word-aligned target.
//   Ports:
//     clk         : rising-edge clock
//     reset       : asynchronous active-low reset
//     im_addr     : instruction memory byte address (the PC)
//     im_data     : instruction word for im_addr (combinational memory)
//     redirect    : taken branch; flush and reload the PC
//     redirect_pc : branch target, low two bits ignored
//     out_valid   : queue head holds an instruction
//     out_instr   : head instruction
//     out_pc      : PC of the head instruction
//     out_ready   : IF/ID takes the head this cycle
//     occupancy   : number of queued entries
// -----------------------------------------------------------------------------
module fetch_queue_unit
  import lego_pkg::*;
#(
  parameter int           N        = 64,
  parameter int           DEPTH    = 2,
  parameter logic [N-1:0] RESET_PC = {N{1'b0}}
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [N-1:0]           im_addr,
  input  logic [INSTR_W-1:0]     im_data,
  input  logic                   redirect,
  input  logic [N-1:0]           redirect_pc,
  output logic                   out_valid,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [N-1:0]           out_pc,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int ENT_W = N + INSTR_W;

  logic [N-1:0]     pc_q, pc_d;
  logic             pop_s;
  logic             push_s;
  logic             full_s;
  logic             empty_s;
  logic [ENT_W-1:0] wr_entry_s;
  logic [ENT_W-1:0] head_s;
  logic             unused_s;

  // The low target bits are architecturally zero for aligned instructions.
  assign unused_s = ^redirect_pc[1:0];

  assign im_addr   = pc_q;
  assign out_valid = ~empty_s;
  assign pop_s     = out_valid & out_ready;
  // Fetch whenever there is room, including the slot freed by this cycle's
  // pop; a redirect suppresses the fetch since the current PC is stale.
  assign push_s    = ~redirect & (~full_s | pop_s);

  assign wr_entry_s = {pc_q, im_data};
  assign out_pc     = head_s[ENT_W-1:INSTR_W];
  assign out_instr  = head_s[INSTR_W-1:0];

  // PC next-state: branch target wins, otherwise advance only on a fetch.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[N-1:2], 2'b00};
    end else if (push_s) begin
      pc_d = pc_q + N'(PC_STEP);
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (redirect),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (wr_entry_s),
    .rdata_o (head_s),
    .count_o (occupancy),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

endmodule : fetch_queue_unit

// File: tb/tb_fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_unit
//   Self-checking bench for fetch_queue_unit with a queue-based reference
//   model of the fetch stage and a hashed combinational instruction memory.
// -----------------------------------------------------------------------------
module tb_fetch_queue_unit;

  localparam int          N        = 64;
  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        reset;
  logic [63:0] im_addr;
  logic [31:0] im_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t        mq[$];
  logic [63:0] mpc;

  function automatic logic [31:0] imem_word(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  assign im_data = imem_word(im_addr);

  fetch_queue_unit #(.N(N), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .im_addr     (im_addr),
    .im_data     (im_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock using the inputs as they stand, then
  // let the DUT take the same edge and settle.
  task automatic step();
    bit pop;
    bit push;
    pop = (mq.size() != 0) && out_ready;
    if (redirect) begin
      mq.delete();
      mpc = {redirect_pc[63:2], 2'b00};
    end else begin
      push = (mq.size() < DEPTH) || pop;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{pc: mpc, instr: imem_word(mpc)});
        mpc = mpc + 64'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    mq.delete();
    mpc = RESET_PC;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; redirect = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;
    mq.delete(); mpc = RESET_PC;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_checks++; if (im_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr got %h want %h", im_addr, RESET_PC); end
    n_checks++; if (out_pc !== 64'h0 || out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_head got %h/%h want 0/0", out_pc, out_instr); end
    reset = 1'b1;
    #1;
  endtask

  task automatic test_startup();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL start_valid[%0d] got %0b want 1", i, out_valid); end
      n_checks++;
      if (out_pc !== 64'(i * 4) || out_instr !== imem_word(64'(i * 4))) begin
        n_fail++; $display("FAIL start_head[%0d] got %h/%h want %h/%h", i, out_pc, out_instr, 64'(i * 4), imem_word(64'(i * 4)));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (occupancy !== 2'(mq.size()) || mq.size() != ((i < 2) ? i + 1 : 2)) begin
        n_fail++; $display("FAIL stall_occ[%0d] got %0d want %0d", i, occupancy, (i < 2) ? i + 1 : 2);
      end
      if (i >= 1) begin
        n_checks++; if (im_addr !== 64'h8) begin n_fail++; $display("FAIL stall_addr[%0d] got %h want 8", i, im_addr); end
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'(i * 4) || out_instr !== imem_word(64'(i * 4))) begin
        n_fail++; $display("FAIL stall_drain[%0d] got v=%0b %h/%h want %h", i, out_valid, out_pc, out_instr, 64'(i * 4));
      end
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    step(); step();
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'h43;
    step();
    redirect = 1'b0;
    n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got occ=%0d v=%0b want 0/0", occupancy, out_valid); end
    n_checks++; if (im_addr !== 64'h40) begin n_fail++; $display("FAIL redir_addr got %h want 40", im_addr); end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h40 || out_instr !== imem_word(64'h40)) begin
      n_fail++; $display("FAIL redir_target got v=%0b %h/%h want 40/%h", out_valid, out_pc, out_instr, imem_word(64'h40));
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] prev;
    do_reset();
    out_ready = 1'b0;
    step(); step();
    out_ready = 1'b1;
    prev = im_addr;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL b2b_occ[%0d] got %0d want 2", i, occupancy); end
      n_checks++; if (im_addr !== prev + 64'd4) begin n_fail++; $display("FAIL b2b_pc[%0d] got %h want %h", i, im_addr, prev + 64'd4); end
      prev = prev + 64'd4;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    step(); step();
    n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL arst_pre got %0d want 2", occupancy); end
    reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL arst_fifo got v=%0b occ=%0d want 0/0", out_valid, occupancy); end
    n_checks++; if (im_addr !== RESET_PC) begin n_fail++; $display("FAIL arst_addr got %h want %h", im_addr, RESET_PC); end
    mq.delete(); mpc = RESET_PC;
    reset = 1'b1;
    #1;
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin n_fail++; $display("FAIL arst_restart got v=%0b %h want %h", out_valid, out_pc, RESET_PC); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    redirect = 1'b0;
    step();
    n_checks++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL wrap_last got %h want fffffffffffffffc", out_pc); end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== imem_word(64'h0)) begin
      n_fail++; $display("FAIL wrap_zero got v=%0b %h/%h want 0/%h", out_valid, out_pc, out_instr, imem_word(64'h0));
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 7) == 0);
      redirect_pc = {$urandom, $urandom};
      step();
      n_checks++;
      if (out_valid !== (mq.size() != 0) || occupancy !== 2'(mq.size()) || im_addr !== mpc) begin
        n_fail++; $display("FAIL rand_state[%0d] got v=%0b occ=%0d a=%h want occ=%0d a=%h", i, out_valid, occupancy, im_addr, mq.size(), mpc);
      end
      if (mq.size() != 0) begin
        n_checks++;
        if (out_pc !== mq[0].pc || out_instr !== mq[0].instr) begin
          n_fail++; $display("FAIL rand_head[%0d] got %h/%h want %h/%h", i, out_pc, out_instr, mq[0].pc, mq[0].instr);
        end
      end
    end
    redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_queue_unit
